// File: rtl/mmio_display_ctrl.sv
// MMIO LED and multiplexed 7-segment display controller with frame-synchronous
// double buffering, leading-zero blanking, blink, display enable and readback.
module mmio_display_ctrl #(
    parameter int unsigned LED_WIDTH    = 16,
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  led_we,
    input  logic                  seg_we,
    input  logic                  mode_we,
    input  logic [31:0]           wdata,
    input  logic [1:0]            rd_sel,
    output logic [31:0]           rdata,
    output logic [LED_WIDTH-1:0]  led_out,
    output logic [7:0]            seg_lo,
    output logic [7:0]            seg_hi,
    output logic [NUM_DIGITS-1:0] dig_sel
);

    localparam int unsigned HALF  = NUM_DIGITS / 2;
    localparam int unsigned HEX_W = 4 * NUM_DIGITS;
    localparam int unsigned PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [HEX_W-1:0]      pending;
    logic [HEX_W-1:0]      active;
    logic [2:0]            mode;
    logic [PS_W-1:0]       prescaler;
    logic [IDX_W-1:0]      idx;
    logic [BF_W-1:0]       blink_cnt;
    logic                  blink_phase;

    logic                  tick;
    logic                  wrap;
    logic                  frame_end;
    logic                  any_nz;
    logic [NUM_DIGITS-1:0] keep;
    logic [7:0]            seg_lo_d;
    logic [7:0]            seg_hi_d;
    logic [NUM_DIGITS-1:0] dig_sel_d;

    function automatic logic [7:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 8'h3F;
            4'h1: hex7 = 8'h06;
            4'h2: hex7 = 8'h5B;
            4'h3: hex7 = 8'h4F;
            4'h4: hex7 = 8'h66;
            4'h5: hex7 = 8'h6D;
            4'h6: hex7 = 8'h7D;
            4'h7: hex7 = 8'h07;
            4'h8: hex7 = 8'h7F;
            4'h9: hex7 = 8'h6F;
            4'hA: hex7 = 8'h77;
            4'hB: hex7 = 8'h7C;
            4'hC: hex7 = 8'h39;
            4'hD: hex7 = 8'h5E;
            4'hE: hex7 = 8'h79;
            default: hex7 = 8'h71;
        endcase
    endfunction

    assign tick      = (prescaler == PS_W'(SCAN_DIV - 1));
    assign wrap      = (idx == IDX_W'(HALF - 1));
    assign frame_end = tick && wrap;

    // Scan from the most significant digit down so each digit knows whether
    // anything non-zero sits at or above it.
    always_comb begin
        any_nz = 1'b0;
        keep   = '0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            any_nz = any_nz | (active[4*(NUM_DIGITS-1-j) +: 4] != 4'h0);
            keep[NUM_DIGITS-1-j] = any_nz || !mode[1] || (j == NUM_DIGITS - 1);
        end
    end

    always_comb begin
        dig_sel_d = '0;
        seg_lo_d  = '0;
        seg_hi_d  = '0;
        if (mode[0]) begin
            for (int unsigned k = 0; k < HALF; k++) begin
                if (idx == IDX_W'(k)) begin
                    dig_sel_d[k]        = 1'b1;
                    dig_sel_d[k + HALF] = 1'b1;
                    if (!(mode[2] && blink_phase)) begin
                        if (keep[k])
                            seg_lo_d = hex7(active[4*k +: 4]);
                        if (keep[k + HALF])
                            seg_hi_d = hex7(active[4*(k + HALF) +: 4]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_out     <= '0;
            pending     <= '0;
            active      <= '0;
            mode        <= 3'b001;
            prescaler   <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            seg_lo      <= '0;
            seg_hi      <= '0;
            dig_sel     <= '0;
        end else begin
            if (led_we)
                led_out <= wdata[LED_WIDTH-1:0];
            if (mode_we)
                mode <= wdata[2:0];
            // A write on the commit edge lands in pending; active takes the old value.
            if (seg_we)
                pending <= wdata[HEX_W-1:0];
            if (frame_end)
                active <= pending;

            prescaler <= tick ? '0 : prescaler + PS_W'(1);
            if (tick)
                idx <= wrap ? '0 : idx + IDX_W'(1);

            if (frame_end) begin
                if (blink_cnt == BF_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BF_W'(1);
                end
            end

            seg_lo  <= seg_lo_d;
            seg_hi  <= seg_hi_d;
            dig_sel <= dig_sel_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (rd_sel)
            2'd0:    rdata[LED_WIDTH-1:0] = led_out;
            2'd1:    rdata[HEX_W-1:0]     = pending;
            2'd2:    rdata[HEX_W-1:0]     = active;
            default: rdata[2:0]           = mode;
        endcase
    end

endmodule
